apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
// - APB requester: turns single-beat commands from a local valid/ready port into APB SETUP/ACCESS transfers.
// - Drives the 32-location APB memory-slave bus and returns read data and error per command.
// - Adds a wait-state timeout so a slave that never raises PREADY cannot hang the bus.
// PARAMETERS
// - ADDR_W      32  width of PADDR and cmd_addr
// - DATA_W      32  width of PWDATA/PRDATA and command/response data
// - TIMEOUT     16  max ACCESS cycles with PREADY low before abort; range 1..255
// PORTS
// - PCLK        in   1       clock; all logic on rising edge
// - PRESET      in   1       reset, synchronous, active-high
// - cmd_valid   in   1       command present
// - cmd_ready   out  1       command accepted when cmd_valid & cmd_ready at PCLK edge
// - cmd_write   in   1       1 = write, 0 = read
// - cmd_addr    in   ADDR_W  target address
// - cmd_wdata   in   DATA_W  write data (ignored for reads)
// - rsp_valid   out  1       one-cycle pulse: transfer finished
// - rsp_rdata   out  DATA_W  PRDATA captured on completion (0 for writes/timeouts)
// - rsp_err     out  1       PSLVERR captured on completion, or timeout
// - rsp_timeout out  1       transfer aborted by timeout (rsp_err also 1)
// - PSEL, PENABLE, PWRITE  out 1 each   APB control
// - PADDR       out  ADDR_W  APB address
// - PWDATA      out  DATA_W  APB write data
// - PRDATA      in   DATA_W  APB read data
// - PREADY      in   1       APB ready
// - PSLVERR     in   1       APB slave error, sampled only with PREADY
// BEHAVIOUR
// - Reset (PRESET=1 at edge): state IDLE; PSEL=PENABLE=PWRITE=0; PADDR=PWDATA=0; rsp_*=0; timer=0.
//   Reset mid-transfer drops PSEL/PENABLE next edge; no rsp_valid for the aborted command.
// - cmd_ready = 1 in IDLE, and in ACCESS during the completing cycle (PREADY=1 or timeout); else 0.
// - On accept: latch cmd into PADDR/PWRITE/PWDATA; go SETUP (PSEL=1, PENABLE=0).
// - SETUP: exactly one cycle; then ACCESS (PENABLE=1). PADDR/PWRITE/PWDATA/PSEL held stable.
// - ACCESS, PREADY=0: stay; timer++. PREADY=1: complete; rsp_valid pulse next cycle with
//   rsp_rdata = PRDATA (read) or 0 (write), rsp_err = PSLVERR.
// - Timeout: in ACCESS with timer==TIMEOUT-1 and PREADY=0 -> complete with rsp_err=1, rsp_timeout=1.
// - Completion with a command accepted in the same cycle (back-to-back): next state SETUP,
//   PSEL stays 1, PENABLE drops to 0; no IDLE cycle. Otherwise next state IDLE, PSEL=0, PENABLE=0.
// - Min transfer latency: accept edge -> rsp_valid = 3 cycles (SETUP, ACCESS, response).
// - PREADY/PSLVERR/PRDATA ignored outside ACCESS. Timer cleared on entering SETUP.
// - No response backpressure: consumer must take rsp_valid when pulsed.
// - Illegal state encoding -> IDLE next edge, outputs as reset.
// STRUCTURE
// - apb_pkg: typedef enum logic [1:0] {APB_IDLE=2'b00, APB_SETUP=2'b01, APB_ACCESS=2'b10};
//   APB_MEM_DEPTH=32, APB_ERASED=32'hFFFF_FFFF, shared with the APB slave and bench.
// - One sub-module: apb_wait_timer (load/clear, count enable, expired flag, width $clog2(TIMEOUT+1)).
// TESTING (bench pairs this block with the APB memory slave)
// - Write 0xDEAD_BEEF to 0x04, then read 0x04 -> rsp_rdata=0xDEAD_BEEF, rsp_err=0; 3-cycle latency each.
// - Read 0x08 after reset (erased) -> rsp_rdata=0xFFFF_FFFF, rsp_err=1.
// - Read 0x20 (out of range) -> rsp_rdata=0, rsp_err=1; following write to 0x00 succeeds, rsp_err=0.
// - Two writes with cmd_valid held -> PSEL stays 1, no IDLE between; PENABLE pattern 0,1,0,1.
// - Stub slave holds PREADY=0 -> after 16 ACCESS cycles rsp_err=1, rsp_timeout=1, PSEL=0.
// - Assert PRESET during ACCESS -> next edge PSEL=PENABLE=0, no rsp_valid; new command then works.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and memory-slave constants,
// used by the bridge, the APB memory slave and the bench.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ACCESS = 2'b10
    } apb_state_t;

    localparam int          APB_MEM_DEPTH = 32;
    localparam logic [31:0] APB_ERASED    = 32'hFFFF_FFFF;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase. Cleared when a new transfer
// starts, counts cycles in which the slave holds PREADY low, and flags the
// last permitted wait cycle so the requester can abort on that edge.
module apb_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Counter: reset or clear wins over counting.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: accepts single-beat commands on a valid/ready port, runs
// each as an APB SETUP/ACCESS transfer and returns a one-cycle response with
// read data and error status. A wait-state timer aborts transfers whose slave
// never raises PREADY.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    apb_state_t state;
    apb_state_t state_next;
    logic       accept;
    logic       done;
    logic       expired;
    logic       state_legal;
    logic       timer_count;

    // A corrupted state register is treated exactly like reset.
    assign state_legal = (state == APB_IDLE) || (state == APB_SETUP) || (state == APB_ACCESS);

    // Transfer completes in ACCESS on PREADY or on the last allowed wait cycle.
    assign done        = (state == APB_ACCESS) && (PREADY || expired);
    assign accept      = cmd_valid && cmd_ready;
    assign timer_count = (state == APB_ACCESS) && !PREADY;

    // APB control strobes follow directly from the phase.
    assign PSEL    = (state == APB_SETUP) || (state == APB_ACCESS);
    assign PENABLE = (state == APB_ACCESS);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (TMR_W)
    ) u_wait_timer (
        .clk      (PCLK),
        .rst      (PRESET),
        .clear    (accept),
        .count_en (timer_count),
        .expired  (expired)
    );

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= APB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and command handshake; a completing ACCESS may accept the next command.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        case (state)
            APB_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = APB_SETUP;
                end
            end
            APB_SETUP: begin
                state_next = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (PREADY || expired) begin
                    cmd_ready  = 1'b1;
                    state_next = cmd_valid ? APB_SETUP : APB_IDLE;
                end
            end
            default: begin
                state_next = APB_IDLE;
            end
        endcase
    end

    // Address/data latch on accept and one-cycle response capture on completion.
    always_ff @(posedge PCLK) begin
        if (PRESET || !state_legal) begin
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= done;
            rsp_rdata   <= (done && PREADY && !PWRITE) ? PRDATA : '0;
            rsp_err     <= done && (PREADY ? PSLVERR : 1'b1);
            rsp_timeout <= done && !PREADY;
            if (accept) begin
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
                PWRITE <= cmd_write;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge paired with a behavioural 32-location APB
// memory slave. Directed table, multi-cycle corner sequences and a random
// phase checked against an abstract memory model.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    apb_master_bridge #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          cyc;
    } rsp_t;

    int   vecCount = 0;
    int   missCount = 0;
    int   cyc = 0;
    rsp_t rspQ[$];
    rsp_t expQ[$];

    // Behavioural APB memory slave with optional random wait states or a permanent stall
    logic              stallMode = 1'b0;
    logic              randWaits = 1'b0;
    int                waitLeft = 0;
    logic [DATA_W-1:0] slvMem [APB_MEM_DEPTH];
    logic [APB_MEM_DEPTH-1:0] slvWritten = '0;

    always_comb begin
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (PSEL && PENABLE && !stallMode && waitLeft == 0) begin
            PREADY = 1'b1;
            if (PADDR < APB_MEM_DEPTH) begin
                if (!PWRITE) begin
                    PRDATA  = slvWritten[PADDR[4:0]] ? slvMem[PADDR[4:0]] : APB_ERASED;
                    PSLVERR = !slvWritten[PADDR[4:0]];
                end
            end else begin
                PSLVERR = 1'b1;
            end
        end
    end

    always @(posedge PCLK) begin
        if (PSEL && !PENABLE) begin
            waitLeft <= randWaits ? int'($urandom_range(0, 3)) : 0;
        end else if (PSEL && PENABLE && !PREADY && waitLeft > 0) begin
            waitLeft <= waitLeft - 1;
        end
        if (PSEL && PENABLE && PREADY && PWRITE && PADDR < APB_MEM_DEPTH) begin
            slvMem[PADDR[4:0]]     <= PWDATA;
            slvWritten[PADDR[4:0]] <= 1'b1;
        end
    end

    // Response monitor: timestamps every rsp_valid pulse by negedge count
    always @(negedge PCLK) begin
        cyc <= cyc + 1;
        if (rsp_valid) begin
            rspQ.push_back('{rsp_rdata, rsp_err, rsp_timeout, cyc + 1});
        end
    end

    // Reference model: plain memory semantics of the slave as seen through the bridge
    logic [31:0]              refMem [APB_MEM_DEPTH];
    logic [APB_MEM_DEPTH-1:0] refWritten = '0;

    task automatic refExecute(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
        if (addr >= APB_MEM_DEPTH) begin
            rdata = 32'h0;
            err   = 1'b1;
        end else if (write) begin
            refMem[addr[4:0]]     = wdata;
            refWritten[addr[4:0]] = 1'b1;
            rdata = 32'h0;
            err   = 1'b0;
        end else if (!refWritten[addr[4:0]]) begin
            rdata = APB_ERASED;
            err   = 1'b1;
        end else begin
            rdata = refMem[addr[4:0]];
            err   = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called near a negedge; returns just after the negedge following the accept edge
    task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                 output int acceptCyc);
        int tries;
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tries = 0;
        while (!cmd_ready && tries < 100) begin
            @(negedge PCLK);
            tries++;
        end
        if (!cmd_ready) begin
            checkOutput("accept_bound", 64'(cmd_ready), 64'd1);
        end
        @(posedge PCLK);
        acceptCyc = cyc;
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic waitResponse(output rsp_t r, output logic got);
        for (int i = 0; i < 60 && rspQ.size() == 0; i++) begin
            @(posedge PCLK);
        end
        got = (rspQ.size() != 0);
        if (got) begin
            r = rspQ.pop_front();
        end else begin
            r = '{32'h0, 1'b0, 1'b0, 0};
        end
        checkOutput("rsp_arrived", 64'(got), 64'd1);
    endtask

    task automatic doReset();
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        int          acc;
        rsp_t        r;
        logic        got;
        logic [31:0] er;
        logic        ee;
        logic [7:0]  pat;
        int          accessCnt;

        vecs[0] = '{1'b1, 32'h04, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h08, 32'h0,         32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{1'b0, 32'h20, 32'h0,         32'h0,         1'b1};
        vecs[4] = '{1'b1, 32'h00, 32'h1234_5678, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h00, 32'h0,         32'h1234_5678, 1'b0};
        vecs[6] = '{1'b1, 32'h1F, 32'h0BAD_F00D, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 32'h1F, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[8] = '{1'b1, 32'h20, 32'h5555_AAAA, 32'h0,         1'b1};

        @(negedge PCLK);
        doReset();
        checkOutput("reset_psel",    64'(PSEL),        64'd0);
        checkOutput("reset_penable", 64'(PENABLE),     64'd0);
        checkOutput("reset_pwrite",  64'(PWRITE),      64'd0);
        checkOutput("reset_paddr",   64'(PADDR),       64'd0);
        checkOutput("reset_pwdata",  64'(PWDATA),      64'd0);
        checkOutput("reset_rsp",     64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        checkOutput("reset_rdata",   64'(rsp_rdata),   64'd0);
        checkOutput("reset_ready",   64'(cmd_ready),   64'd1);

        // Directed table with zero-wait slave
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, acc);
            refExecute(vecs[i].write, vecs[i].addr, vecs[i].wdata, er, ee);
            waitResponse(r, got);
            checkOutput($sformatf("vec%0d_rdata", i), 64'(r.rdata), 64'(vecs[i].expRdata));
            checkOutput($sformatf("vec%0d_err", i),   64'(r.err),   64'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_tmo", i),   64'(r.tmo),   64'd0);
            checkOutput($sformatf("vec%0d_latency", i), 64'(r.cyc - acc), 64'd3);
            @(negedge PCLK);
        end

        // Back-to-back writes with cmd_valid held across the completing cycle
        rspQ.delete();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h01;
        cmd_wdata = 32'hA5A5_0001;
        refExecute(1'b1, 32'h01, 32'hA5A5_0001, er, ee);
        @(posedge PCLK);
        @(negedge PCLK);
        pat[7:6] = {PSEL, PENABLE};
        cmd_addr  = 32'h02;
        cmd_wdata = 32'hA5A5_0002;
        refExecute(1'b1, 32'h02, 32'hA5A5_0002, er, ee);
        @(negedge PCLK);
        pat[5:4] = {PSEL, PENABLE};
        @(negedge PCLK);
        pat[3:2] = {PSEL, PENABLE};
        cmd_valid = 1'b0;
        @(negedge PCLK);
        pat[1:0] = {PSEL, PENABLE};
        checkOutput("b2b_psel_penable", 64'(pat), 64'b10_11_10_11);
        waitResponse(r, got);
        checkOutput("b2b_first_err", 64'(r.err), 64'd0);
        waitResponse(r, got);
        checkOutput("b2b_second_err", 64'(r.err), 64'd0);
        @(negedge PCLK);

        // Stalled slave: transfer must abort after TIMEOUT access cycles
        rspQ.delete();
        stallMode = 1'b1;
        applyStimulus(1'b0, 32'h04, 32'h0, acc);
        accessCnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            #1;
            if (rspQ.size() != 0) break;
            if (PENABLE) accessCnt++;
        end
        checkOutput("tmo_access_cycles", 64'(accessCnt), 64'(TIMEOUT));
        checkOutput("tmo_psel", 64'(PSEL), 64'd0);
        waitResponse(r, got);
        checkOutput("tmo_err",   64'(r.err),   64'd1);
        checkOutput("tmo_flag",  64'(r.tmo),   64'd1);
        checkOutput("tmo_rdata", 64'(r.rdata), 64'd0);
        stallMode = 1'b0;
        @(negedge PCLK);

        // Reset during ACCESS drops the strobes and suppresses the response
        rspQ.delete();
        stallMode = 1'b1;
        applyStimulus(1'b1, 32'h06, 32'hCAFE_0006, acc);
        @(negedge PCLK);
        checkOutput("rst_mid_in_access", 64'(PENABLE), 64'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        checkOutput("rst_mid_strobes", 64'({PSEL, PENABLE}), 64'd0);
        PRESET    = 1'b0;
        stallMode = 1'b0;
        repeat (5) @(negedge PCLK);
        checkOutput("rst_mid_no_rsp", 64'(rspQ.size()), 64'd0);
        applyStimulus(1'b1, 32'h10, 32'h0000_1234, acc);
        refExecute(1'b1, 32'h10, 32'h0000_1234, er, ee);
        waitResponse(r, got);
        checkOutput("post_rst_write_err", 64'(r.err), 64'd0);
        @(negedge PCLK);
        applyStimulus(1'b0, 32'h10, 32'h0, acc);
        refExecute(1'b0, 32'h10, 32'h0, er, ee);
        waitResponse(r, got);
        checkOutput("post_rst_read_data", 64'(r.rdata), 64'h1234);
        checkOutput("post_rst_latency", 64'(r.cyc - acc), 64'd3);
        @(negedge PCLK);

        // Random traffic with random wait states against the memory model
        rspQ.delete();
        expQ.delete();
        randWaits = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic        w;
            logic [31:0] a;
            logic [31:0] d;
            int          gap;
            w   = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 39));
            d   = $urandom;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge PCLK);
            applyStimulus(w, a, d, acc);
            refExecute(w, a, d, er, ee);
            expQ.push_back('{er, ee, 1'b0, 0});
        end
        for (int i = 0; i < 100 && rspQ.size() < expQ.size(); i++) begin
            @(posedge PCLK);
        end
        checkOutput("rand_rsp_count", 64'(rspQ.size()), 64'(expQ.size()));
        for (int i = 0; rspQ.size() != 0 && expQ.size() != 0; i++) begin
            rsp_t g;
            rsp_t e;
            g = rspQ.pop_front();
            e = expQ.pop_front();
            checkOutput($sformatf("rand%0d_rdata", i), 64'(g.rdata), 64'(e.rdata));
            checkOutput($sformatf("rand%0d_err", i),   64'(g.err),   64'(e.err));
            checkOutput($sformatf("rand%0d_tmo", i),   64'(g.tmo),   64'(e.tmo));
        end
        randWaits = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
